// File: rtl/alu_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_sequencer_if : request/response handshake and ALU strobe bundle    |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
interface alu_sequencer_if #(
    parameter int WIDTH = 262,
    parameter int OPW   = 7
);
    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_op;
    logic [WIDTH-1:0] req_src1;
    logic [WIDTH-1:0] req_src2;
    logic             req_wide;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic [WIDTH-1:0] resp_over;
    logic             resp_timeout;

    logic             alu_enable;
    logic             alu_in1;
    logic             alu_in2;
    logic             alu_compute;
    logic             alu_out;
    logic             alu_over;
    logic [OPW-1:0]   alu_operation;
    logic             alu_done;

    // master is the sequencer; slave is the requester/consumer/ALU side
    modport master (
        input  req_valid, req_op, req_src1, req_src2, req_wide, resp_ready, alu_done,
        output req_ready, resp_valid, resp_result, resp_over, resp_timeout,
        output alu_enable, alu_in1, alu_in2, alu_compute, alu_out, alu_over, alu_operation
    );

    modport slave (
        output req_valid, req_op, req_src1, req_src2, req_wide, resp_ready, alu_done,
        input  req_ready, resp_valid, resp_result, resp_over, resp_timeout,
        input  alu_enable, alu_in1, alu_in2, alu_compute, alu_out, alu_over, alu_operation
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_sequencer : sequences one operation through the shared-bus ALU     |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int WIDTH   = 262,
    parameter int OPW     = 7,
    parameter int TIMEOUT = 64
) (
    input  wire logic        clock,
    input  wire logic        reset,
    alu_sequencer_if.master  sif,
    inout  wire [WIDTH-1:0]  bus
);
    localparam int            CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD1     = 3'd1;
    localparam logic [2:0] S_LOAD2     = 3'd2;
    localparam logic [2:0] S_COMPUTE   = 3'd3;
    localparam logic [2:0] S_READ      = 3'd4;
    localparam logic [2:0] S_READ_OVER = 3'd5;
    localparam logic [2:0] S_RESP      = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic             r_wide;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_over;
    logic             r_timeout;

    logic             w_enable;
    logic             w_in1;
    logic             w_in2;
    logic             w_compute;
    logic             w_out;
    logic             w_over;
    logic             w_drive;
    logic [WIDTH-1:0] w_bus_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (sif.req_valid) w_next = S_LOAD1;
            S_LOAD1:     w_next = S_LOAD2;
            S_LOAD2:     w_next = S_COMPUTE;
            // done takes priority over an expiring counter
            S_COMPUTE: begin
                if (sif.alu_done) begin
                    w_next = S_READ;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_next = S_RESP;
                end
            end
            S_READ:      w_next = r_wide ? S_READ_OVER : S_RESP;
            S_READ_OVER: w_next = S_RESP;
            S_RESP:      if (sif.resp_ready) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_enable   = 1'b0;
        w_in1      = 1'b0;
        w_in2      = 1'b0;
        w_compute  = 1'b0;
        w_out      = 1'b0;
        w_over     = 1'b0;
        w_drive    = 1'b0;
        w_bus_data = r_src1;
        case (r_state)
            S_LOAD1: begin
                w_enable = 1'b1;
                w_in1    = 1'b1;
                w_drive  = 1'b1;
            end
            S_LOAD2: begin
                w_enable   = 1'b1;
                w_in2      = 1'b1;
                w_drive    = 1'b1;
                w_bus_data = r_src2;
            end
            S_COMPUTE: begin
                w_enable  = 1'b1;
                w_compute = 1'b1;
            end
            S_READ: begin
                w_enable = 1'b1;
                w_out    = 1'b1;
            end
            S_READ_OVER: begin
                w_enable = 1'b1;
                w_over   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op      <= '0;
            r_wide    <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_over    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sif.req_valid) begin
                        r_op      <= sif.req_op;
                        r_wide    <= sif.req_wide;
                        r_result  <= '0;
                        r_over    <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_LOAD2:     r_cnt <= '0;
                S_COMPUTE: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (!sif.alu_done && (r_cnt == C_CNT_LAST)) begin
                        r_timeout <= 1'b1;
                    end
                end
                S_READ:      r_result <= bus;
                S_READ_OVER: r_over   <= bus;
                default: ;
            endcase
        end
    end

    // operand holding registers are pure datapath and need no reset
    always_ff @(posedge clock) begin
        if ((r_state == S_IDLE) && sif.req_valid) begin
            r_src1 <= sif.req_src1;
            r_src2 <= sif.req_src2;
        end
    end

    assign sif.req_ready     = (r_state == S_IDLE);
    assign sif.resp_valid    = (r_state == S_RESP);
    assign sif.resp_result   = r_result;
    assign sif.resp_over     = r_over;
    assign sif.resp_timeout  = r_timeout;
    assign sif.alu_enable    = w_enable;
    assign sif.alu_in1       = w_in1;
    assign sif.alu_in2       = w_in2;
    assign sif.alu_compute   = w_compute;
    assign sif.alu_out       = w_out;
    assign sif.alu_over      = w_over;
    assign sif.alu_operation = w_enable ? r_op : '0;

    assign bus = w_drive ? w_bus_data : {WIDTH{1'bz}};
endmodule
`default_nettype wire
